// File: rtl/evm_pkg.sv
// Shared types and helpers for the EVM display controller: state encoding,
// candidate-index width and tally-to-LED formatting.
package evm_pkg;

  typedef enum logic [2:0] {
    VOTE_IDLE,
    VOTE_ACK,
    RES_SHOW,
    RES_SCAN,
    RES_WIN
  } evm_disp_state_t;

  function automatic int cand_idx_w(input int num_cand);
    return (num_cand <= 2) ? 1 : $clog2(num_cand);
  endfunction

  // Saturate a tally to the largest value an led_w-bit bank can show.
  function automatic logic [31:0] sat_format(input logic [31:0] tally, input int led_w);
    logic [31:0] lim;
    if (led_w >= 32) return tally;
    lim = (32'd1 << led_w) - 32'd1;
    return (tally > lim) ? lim : tally;
  endfunction

endpackage

// File: rtl/evm_max_scan.sv
// Sequential winner scan: one candidate per cycle against a running max,
// lower index kept on equality, tie flag raised on any equal maximum.
module evm_max_scan #(
  parameter int NUM_CAND = 4,
  parameter int VOTE_W   = 8,
  parameter int IDX_W    = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [NUM_CAND*VOTE_W-1:0] votes_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [IDX_W-1:0]           res_idx_o,
  output logic [VOTE_W-1:0]          res_max_o,
  output logic                       res_tie_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CAND - 1);

  logic              busy_q;
  logic [IDX_W-1:0]  idx_q;
  logic [VOTE_W-1:0] max_q, max_d, cur;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d;
  logic              tie_q, tie_d;

  // Candidate 0 seeds the running max, so stale data from a previous scan never leaks in.
  always_comb begin
    cur       = votes_i[int'(idx_q)*VOTE_W +: VOTE_W];
    max_d     = max_q;
    max_idx_d = max_idx_q;
    tie_d     = tie_q;
    if (idx_q == '0 || cur > max_q) begin
      max_d     = cur;
      max_idx_d = idx_q;
      tie_d     = 1'b0;
    end else if (cur == max_q) begin
      tie_d = 1'b1;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (idx_q == LAST);
  assign res_idx_o = max_idx_d;
  assign res_max_o = max_d;
  assign res_tie_o = tie_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      idx_q  <= '0;
    end else if (busy_q) begin
      if (idx_q == LAST) busy_q <= 1'b0;
      else               idx_q  <= idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (busy_q) begin
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      tie_q     <= tie_d;
    end
  end

endmodule

// File: rtl/evm_display_ctrl.sv
// Mode and front-panel display controller for the voting machine: vote
// acknowledge flash, per-candidate tally display and winner reporting.
module evm_display_ctrl
  import evm_pkg::*;
#(
  parameter int NUM_CAND   = 4,
  parameter int VOTE_W     = 8,
  parameter int LED_W      = 8,
  parameter int ACK_CYCLES = 10
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 mode,
  input  logic                                 valid_vote_casted,
  input  logic [NUM_CAND*VOTE_W-1:0]           votes,
  input  logic [NUM_CAND-1:0]                  button_press,
  input  logic                                 winner_req,
  output logic [LED_W-1:0]                     leds,
  output logic                                 ack_busy,
  output logic                                 scan_busy,
  output logic [cand_idx_w(NUM_CAND)-1:0]      winner_idx,
  output logic                                 tie
);

  localparam int IDX_W = cand_idx_w(NUM_CAND);
  localparam int CNT_W = $clog2(ACK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(ACK_CYCLES);

  evm_disp_state_t   state_q, state_d;
  logic [CNT_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic              sel_vld_q, sel_vld_d;
  logic [IDX_W-1:0]  sel_idx_q, sel_idx_d;
  logic [LED_W-1:0]  leds_q, leds_d;
  logic              ack_busy_q, ack_busy_d;
  logic [IDX_W-1:0]  winner_idx_q, winner_idx_d;
  logic              tie_q, tie_d;

  logic              press_any;
  logic [IDX_W-1:0]  press_idx;
  logic              scan_start, scan_abort, scan_busy_w, scan_done, scan_tie;
  logic [IDX_W-1:0]  scan_idx;
  logic [VOTE_W-1:0] scan_max;

  function automatic logic [LED_W-1:0] fmt(input logic [VOTE_W-1:0] v);
    logic [31:0] f;
    f = sat_format(32'(v), LED_W);
    return f[LED_W-1:0];
  endfunction

  // Lowest-index pressed button wins.
  always_comb begin
    press_any = |button_press;
    press_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--)
      if (button_press[i]) press_idx = IDX_W'(i);
  end

  assign scan_start = (state_q == RES_SHOW) && mode && winner_req;
  assign scan_abort = !mode;

  evm_max_scan #(
    .NUM_CAND (NUM_CAND),
    .VOTE_W   (VOTE_W),
    .IDX_W    (IDX_W)
  ) u_scan (
    .clock     (clock),
    .reset_n   (reset_n),
    .start_i   (scan_start),
    .abort_i   (scan_abort),
    .votes_i   (votes),
    .busy_o    (scan_busy_w),
    .done_o    (scan_done),
    .res_idx_o (scan_idx),
    .res_max_o (scan_max),
    .res_tie_o (scan_tie)
  );

  always_comb begin
    state_d      = state_q;
    ack_cnt_d    = ack_cnt_q;
    sel_vld_d    = sel_vld_q;
    sel_idx_d    = sel_idx_q;
    winner_idx_d = winner_idx_q;
    tie_d        = tie_q;
    leds_d       = leds_q;
    unique case (state_q)
      VOTE_IDLE: begin
        if (mode) begin
          state_d = RES_SHOW;
        end else if (valid_vote_casted) begin
          state_d   = VOTE_ACK;
          ack_cnt_d = CNT_ONE;
        end
      end
      VOTE_ACK: begin
        if (mode) begin
          state_d   = RES_SHOW;
          ack_cnt_d = '0;
        end else if (valid_vote_casted) begin
          ack_cnt_d = CNT_ONE;
        end else if (ack_cnt_q == CNT_END) begin
          state_d   = VOTE_IDLE;
          ack_cnt_d = '0;
        end else begin
          ack_cnt_d = ack_cnt_q + CNT_ONE;
        end
      end
      RES_SHOW: begin
        if (!mode) begin
          state_d = VOTE_IDLE;
        end else begin
          if (press_any) begin
            sel_vld_d = 1'b1;
            sel_idx_d = press_idx;
          end
          if (winner_req) state_d = RES_SCAN;
        end
      end
      RES_SCAN: begin
        if (!mode) begin
          state_d = VOTE_IDLE;
        end else if (scan_done) begin
          state_d      = RES_WIN;
          winner_idx_d = scan_idx;
          tie_d        = scan_tie;
        end
      end
      RES_WIN: begin
        if (!mode) begin
          state_d = VOTE_IDLE;
        end else if (press_any) begin
          state_d   = RES_SHOW;
          sel_vld_d = 1'b1;
          sel_idx_d = press_idx;
        end
      end
      default: state_d = VOTE_IDLE;
    endcase

    // LED content follows the state being entered so the display lags its cause by one cycle.
    ack_busy_d = (state_d == VOTE_ACK);
    case (state_d)
      VOTE_ACK: leds_d = '1;
      RES_SHOW: leds_d = sel_vld_d ? fmt(votes[int'(sel_idx_d)*VOTE_W +: VOTE_W]) : '0;
      RES_SCAN: leds_d = leds_q;
      RES_WIN:  leds_d = (state_q == RES_SCAN) ? fmt(scan_max) : leds_q;
      default:  leds_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= VOTE_IDLE;
      ack_cnt_q    <= '0;
      sel_vld_q    <= 1'b0;
      sel_idx_q    <= '0;
      leds_q       <= '0;
      ack_busy_q   <= 1'b0;
      winner_idx_q <= '0;
      tie_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_cnt_q    <= ack_cnt_d;
      sel_vld_q    <= sel_vld_d;
      sel_idx_q    <= sel_idx_d;
      leds_q       <= leds_d;
      ack_busy_q   <= ack_busy_d;
      winner_idx_q <= winner_idx_d;
      tie_q        <= tie_d;
    end
  end

  assign leds       = leds_q;
  assign ack_busy   = ack_busy_q;
  assign scan_busy  = scan_busy_w;
  assign winner_idx = winner_idx_q;
  assign tie        = tie_q;

endmodule

// File: tb/tb_evm_display_ctrl.sv
// Scoreboard bench for evm_display_ctrl: the driver queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_evm_display_ctrl;

  logic        clock = 1'b0;
  logic        reset_n, mode, vld, wreq;
  logic [31:0] votes;
  logic [39:0] votes10;
  logic [3:0]  btn;
  logic [7:0]  leds, leds10;
  logic        ack, ack10, scan, scan10, tie, tie10;
  logic [1:0]  widx, widx10;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  evm_display_ctrl dut (
    .clock(clock), .reset_n(reset_n), .mode(mode), .valid_vote_casted(vld),
    .votes(votes), .button_press(btn), .winner_req(wreq),
    .leds(leds), .ack_busy(ack), .scan_busy(scan), .winner_idx(widx), .tie(tie)
  );

  evm_display_ctrl #(.VOTE_W(10)) dut10 (
    .clock(clock), .reset_n(reset_n), .mode(mode), .valid_vote_casted(vld),
    .votes(votes10), .button_press(btn), .winner_req(wreq),
    .leds(leds10), .ack_busy(ack10), .scan_busy(scan10), .winner_idx(widx10), .tie(tie10)
  );

  typedef struct {
    int         cyc;
    bit         which;
    logic [7:0] leds;
    logic       ack;
    logic       scan;
    logic [1:0] widx;
    logic       tie;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic expq(input int at, input bit which, input string nm, input logic [7:0] l,
                      input logic a, input logic s, input logic [1:0] w, input logic t);
    exp_t ex;
    ex.cyc = at; ex.which = which; ex.leds = l; ex.ack = a; ex.scan = s; ex.widx = w; ex.tie = t;
    q.push_back(ex);
    qn.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  exp_t       e;
  string      en;
  logic [7:0] al;
  logic       aa, as, at;
  logic [1:0] aw;

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e  = q.pop_front();
      en = qn.pop_front();
      n_cmp++;
      if (e.which) begin al = leds10; aa = ack10; as = scan10; aw = widx10; at = tie10; end
      else         begin al = leds;   aa = ack;   as = scan;   aw = widx;   at = tie;   end
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d reached monitor only at cycle %0d", en, e.cyc, cyc);
      end else if ({al, aa, as, aw, at} !== {e.leds, e.ack, e.scan, e.widx, e.tie}) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got leds=%h ack=%b scan=%b widx=%0d tie=%b, want leds=%h ack=%b scan=%b widx=%0d tie=%b",
                 en, cyc, al, aa, as, aw, at, e.leds, e.ack, e.scan, e.widx, e.tie);
      end
    end
  end

  int c, t;

  initial begin
    reset_n = 1'b0; mode = 1'b0; vld = 1'b0; wreq = 1'b0; btn = '0;
    votes   = '0;
    votes10 = {10'd0, 10'd0, 10'd200, 10'd300};
    tick(); tick();
    expq(cyc, 0, "reset",   8'h00, 0, 0, 2'd0, 0);
    expq(cyc, 1, "reset10", 8'h00, 0, 0, 2'd0, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single vote: flash for exactly ten cycles
    c = cyc;
    expq(c,      0, "idle",      8'h00, 0, 0, 2'd0, 0);
    expq(c + 1,  0, "ack_first", 8'hFF, 1, 0, 2'd0, 0);
    expq(c + 10, 0, "ack_last",  8'hFF, 1, 0, 2'd0, 0);
    expq(c + 11, 0, "ack_end",   8'h00, 0, 0, 2'd0, 0);
    vld = 1'b1; tick(); vld = 1'b0;
    repeat (12) tick();

    // Retrigger five cycles into the flash
    c = cyc;
    expq(c + 6,  0, "retrig_mid",  8'hFF, 1, 0, 2'd0, 0);
    expq(c + 15, 0, "retrig_last", 8'hFF, 1, 0, 2'd0, 0);
    expq(c + 16, 0, "retrig_end",  8'h00, 0, 0, 2'd0, 0);
    vld = 1'b1; tick(); vld = 1'b0;
    repeat (4) tick();
    vld = 1'b1; tick(); vld = 1'b0;
    repeat (11) tick();

    // Result mode entered together with a vote: no flash, nothing selected yet
    votes = {8'd40, 8'd25, 8'd25, 8'd7};
    mode = 1'b1; vld = 1'b1;
    expq(cyc + 1, 0, "mode_wins", 8'h00, 0, 0, 2'd0, 0);
    tick(); vld = 1'b0;
    btn = 4'b0010; expq(cyc + 1, 0, "sel_cand1", 8'd25, 0, 0, 2'd0, 0); tick(); btn = '0;
    expq(cyc + 1, 0, "sel_hold", 8'd25, 0, 0, 2'd0, 0); tick();
    btn = 4'b1000; expq(cyc + 1, 0, "sel_cand3", 8'd40, 0, 0, 2'd0, 0); tick();
    btn = 4'b0101; expq(cyc + 1, 0, "sel_lowest", 8'd7, 0, 0, 2'd0, 0); tick(); btn = '0;

    // Tie scan, with a simultaneous button press
    votes = {8'd12, 8'd30, 8'd30, 8'd5};
    expq(cyc + 1, 0, "sel_follows", 8'd5, 0, 0, 2'd0, 0); tick();
    t = cyc;
    wreq = 1'b1; btn = 4'b1000;
    expq(t + 1, 0, "scan_first", 8'd5,  0, 1, 2'd0, 0);
    expq(t + 4, 0, "scan_last",  8'd5,  0, 1, 2'd0, 0);
    expq(t + 5, 0, "scan_tie",   8'd30, 0, 0, 2'd1, 1);
    expq(t + 6, 0, "win_hold",   8'd30, 0, 0, 2'd1, 1);
    tick(); wreq = 1'b0; btn = '0;
    repeat (5) tick();
    btn = 4'b1000; expq(cyc + 1, 0, "win_to_show", 8'd12, 0, 0, 2'd1, 1); tick(); btn = '0;

    // Wide tallies on the 10-bit instance
    btn = 4'b0001; expq(cyc + 1, 1, "sat_300", 8'hFF, 0, 0, 2'd0, 0); tick();
    btn = 4'b0010; expq(cyc + 1, 1, "pass_200", 8'd200, 0, 0, 2'd0, 0); tick(); btn = '0;

    // Scan where a later strictly-greater candidate clears the tie
    votes = {8'd40, 8'd25, 8'd25, 8'd7};
    expq(cyc + 1, 0, "sel_cand1_b", 8'd25, 0, 0, 2'd1, 1); tick();
    t = cyc;
    wreq = 1'b1;
    expq(t + 1, 0, "scan2_first", 8'd25, 0, 1, 2'd1, 1);
    expq(t + 4, 0, "scan2_last",  8'd25, 0, 1, 2'd1, 1);
    expq(t + 5, 0, "tie_cleared", 8'd40, 0, 0, 2'd3, 0);
    tick(); wreq = 1'b0;
    repeat (4) tick();
    btn = 4'b0010; expq(cyc + 1, 0, "back_to_show", 8'd25, 0, 0, 2'd3, 0); tick(); btn = '0;

    // Leaving result mode mid-scan keeps the previous winner
    t = cyc;
    votes = {8'd12, 8'd30, 8'd30, 8'd5};
    wreq = 1'b1;
    expq(t + 1, 0, "scan3_busy", 8'd25, 0, 1, 2'd3, 0);
    tick(); wreq = 1'b0;
    tick();
    mode = 1'b0;
    expq(cyc + 1, 0, "abort_keeps", 8'h00, 0, 0, 2'd3, 0);
    tick();
    wreq = 1'b1;
    expq(cyc + 1, 0, "req_ignored", 8'h00, 0, 0, 2'd3, 0);
    tick(); wreq = 1'b0;

    // Asynchronous reset in the middle of a scan
    mode = 1'b1;
    expq(cyc + 1, 0, "reshow", 8'd30, 0, 0, 2'd3, 0); tick();
    t = cyc;
    wreq = 1'b1;
    expq(t + 1, 0, "scan4_busy", 8'd30, 0, 1, 2'd3, 0);
    tick(); wreq = 1'b0;
    tick();
    reset_n = 1'b0; mode = 1'b0;
    expq(cyc, 0, "async_reset", 8'h00, 0, 0, 2'd0, 0);
    tick();
    reset_n = 1'b1;
    expq(cyc, 0, "post_reset", 8'h00, 0, 0, 2'd0, 0);
    vld = 1'b1;
    expq(cyc + 1, 0, "ack_after_reset", 8'hFF, 1, 0, 2'd0, 0);
    tick(); vld = 1'b0;
    tick();

    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked", q.size());
      n_cmp  += q.size();
      n_fail += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
